// File: rtl/ex_mem_skid_stage.sv
// rtl/ex_mem_skid_stage.sv - EX/MEM pipeline register with a two-entry skid buffer
module ex_mem_skid_stage #(
    parameter int DATA_W        = 32,
    parameter int REG_W         = 5,
    parameter int ZERO_SUPPRESS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] RtData_Forwarded,
    input  logic [REG_W-1:0]  ID_EX_Rd,
    input  logic [REG_W-1:0]  ID_EX_Rt,
    input  logic              ID_EX_RegDst,
    input  logic              ID_EX_RegWrite,
    input  logic              ID_EX_MemWrite,
    input  logic              ID_EX_MemtoReg,
    input  logic              ID_EX_MemRead,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] EX_MEM_ALUResult,
    output logic [DATA_W-1:0] EX_MEM_RtData,
    output logic [REG_W-1:0]  EX_MEM_WriteReg,
    output logic              EX_MEM_RegWrite,
    output logic              EX_MEM_MemWrite,
    output logic              EX_MEM_MemtoReg,
    output logic              EX_MEM_MemRead,
    output logic [1:0]        occupancy
);

    // Entry layout: {alu, rt_data, write_reg, reg_write, mem_write, mem_to_reg, mem_read}
    localparam int ENT_W = 2 * DATA_W + REG_W + 4;

    logic [ENT_W-1:0] head_q, head_d;
    logic [ENT_W-1:0] skid_q, skid_d;
    logic             head_v_q, head_v_d;
    logic             skid_v_q, skid_v_d;
    logic [1:0]       occ_q, occ_d;

    logic [REG_W-1:0] write_reg;
    logic             reg_write;
    logic [ENT_W-1:0] new_ent;
    logic             accept;
    logic             drain;

    always_comb begin
        write_reg = ID_EX_RegDst ? ID_EX_Rd : ID_EX_Rt;
        reg_write = ID_EX_RegWrite & ~((ZERO_SUPPRESS != 0) && (write_reg == '0));
        new_ent   = {ALUResult, RtData_Forwarded, write_reg, reg_write,
                     ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_MemRead};
        accept    = in_valid & ~skid_v_q & ~flush;
        drain     = head_v_q & out_ready;
    end

    // Head frees up when empty or draining; the skid entry (older) always moves first.
    always_comb begin
        head_d   = head_q;
        skid_d   = skid_q;
        head_v_d = head_v_q;
        skid_v_d = skid_v_q;
        if (flush) begin
            head_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (!head_v_q || drain) begin
            if (skid_v_q) begin
                head_d   = skid_q;
                head_v_d = 1'b1;
                skid_v_d = accept;
                if (accept) skid_d = new_ent;
            end else begin
                head_v_d = accept;
                if (accept) head_d = new_ent;
            end
        end else if (accept) begin
            skid_d   = new_ent;
            skid_v_d = 1'b1;
        end
        occ_d = {1'b0, head_v_d} + {1'b0, skid_v_d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q   <= '0;
            skid_q   <= '0;
            head_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            head_q   <= head_d;
            skid_q   <= skid_d;
            head_v_q <= head_v_d;
            skid_v_q <= skid_v_d;
            occ_q    <= occ_d;
        end
    end

    always_comb begin
        in_ready         = ~skid_v_q;
        out_valid        = head_v_q;
        occupancy        = occ_q;
        EX_MEM_ALUResult = head_q[ENT_W-1 -: DATA_W];
        EX_MEM_RtData    = head_q[ENT_W-DATA_W-1 -: DATA_W];
        EX_MEM_WriteReg  = head_q[4 +: REG_W];
        EX_MEM_RegWrite  = head_q[3] & head_v_q;
        EX_MEM_MemWrite  = head_q[2] & head_v_q;
        EX_MEM_MemtoReg  = head_q[1] & head_v_q;
        EX_MEM_MemRead   = head_q[0] & head_v_q;
    end

endmodule
